timer_counter_dev: RTL and testbench

Memory-mapped timer/counter peripheral on the CPU's external bus, behind the bridge that decodes m_data_addr into device selects. It counts down from a programmed preset and raises an interrupt request. That request feeds the CPU's `interrupt` input (HWInt) alongside the external interrupt generator. The CPU programs it with sw/lw through a 3-word register window.

---
 rtl/tc_pkg.sv | 40 ++++
 rtl/timer_counter_dev.sv | 124 ++++++++++++
 tb/tb_timer_counter_dev.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the timer/counter peripheral.
// Holds the register window offsets, CTRL bit positions, mode codes, the
// FSM state encoding and a byte-lane merge helper for bus writes.
package tc_pkg;

    // Word offsets inside the 3-word register window (bus addr[3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE codes; 2 and 3 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    // Replace the byte lanes of old_val selected by byteen with new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  byteen);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_counter_dev.sv
// Memory-mapped down-counting timer with interrupt request.
// The CPU programs PRESET and CTRL through a 3-word window; the FSM loads
// COUNT from PRESET, counts down to zero and latches irq_flag. In one-shot
// mode EN is cleared and the flag stays set until the next CTRL write; in
// auto-reload mode the flag is a single-cycle pulse and the count restarts.
//
// Ports:
//   clk     system clock, all state changes on posedge
//   reset   asynchronous active-low reset
//   sel     device selected by the bus bridge this cycle
//   addr    word offset: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved
//   byteen  byte write enables; all-zero means a read
//   wdata   write data
//   rdata   combinational read data (0 when not selected)
//   irq     interrupt request = CTRL.IM & irq_flag
module timer_counter_dev
    import tc_pkg::*;
#(
    parameter int               CNT_W          = 32,
    parameter logic [CNT_W-1:0] RELOAD_DEFAULT = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    tc_state_e        state;
    logic             ctrl_en;
    logic [1:0]       ctrl_mode;
    logic             ctrl_im;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;

    logic             bus_wr;
    logic             ctrl_wr;
    logic             preset_wr;
    logic [31:0]      ctrl_word;
    logic [31:0]      preset_merged;

    assign bus_wr        = sel && (byteen != 4'b0000);
    assign ctrl_wr       = bus_wr && (addr == ADDR_CTRL);
    assign preset_wr     = bus_wr && (addr == ADDR_PRESET);
    assign ctrl_word     = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
    assign preset_merged = merge_bytes(32'(preset), wdata, byteen);

    assign irq = ctrl_im & irq_flag;

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr)
                ADDR_CTRL:   rdata = ctrl_word;
                ADDR_PRESET: rdata = 32'(preset);
                ADDR_COUNT:  rdata = 32'(count);
                default:     rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset    <= RELOAD_DEFAULT;
            count     <= '0;
            irq_flag  <= 1'b0;
        end else begin
            // Any CTRL write acknowledges the interrupt. Placed before the
            // FSM so that an expiry on the same edge still sets the flag.
            if (ctrl_wr) irq_flag <= 1'b0;

            case (state)
                IDLE: if (ctrl_en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl_en) begin
                        state <= IDLE;              // COUNT freezes
                    end else if (count > ONE) begin
                        count <= count - ONE;
                    end else begin
                        // count of 0 or 1 both expire, so PRESET=0 never wraps
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (ctrl_mode == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl_en <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // CPU write to the low CTRL byte overrides the FSM clearing EN.
            if (ctrl_wr && byteen[0]) begin
                ctrl_en   <= wdata[CTRL_EN];
                ctrl_mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                ctrl_im   <= wdata[CTRL_IM];
            end

            // PRESET is only sampled at LOAD, so a mid-count write is deferred.
            if (preset_wr) preset <= preset_merged[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_timer_counter_dev.sv
module tb_timer_counter_dev;
    import tc_pkg::*;

    localparam logic [31:0] RELOAD = 32'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_counter_dev #(.CNT_W(32), .RELOAD_DEFAULT(RELOAD)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr),
        .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Timer lifecycle as three flags: armed (enable seen, loads next edge),
    // running (counting down), expired (reached zero on the last edge).
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    bit          m_armed, m_running, m_expired;

    task automatic model_reset();
        m_en = 0; m_im = 0; m_mode = 2'd0; m_flag = 0;
        m_preset = RELOAD; m_count = 32'd0;
        m_armed = 0; m_running = 0; m_expired = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic s, input logic [1:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
        logic wr;
        logic en_before;
        wr = s && (be != 4'd0);
        en_before = m_en;
        if (wr && a == 2'd0) m_flag = 0;
        if (m_expired) begin
            m_expired = 0;
            if (m_mode == 2'd1) begin m_flag = 0; m_armed = 1; end
            else m_en = 0;
        end else if (m_running) begin
            if (!en_before) m_running = 0;
            else if (m_count > 32'd1) m_count = m_count - 32'd1;
            else begin
                m_count = 32'd0; m_flag = 1; m_running = 0; m_expired = 1;
            end
        end else if (m_armed) begin
            m_count = m_preset; m_armed = 0; m_running = 1;
        end else if (en_before) begin
            m_armed = 1;
        end
        if (wr && a == 2'd0 && be[0]) {m_im, m_mode, m_en} = wd[3:0];
        if (wr && a == 2'd1)
            for (int b = 0; b < 4; b++)
                if (be[b]) m_preset[8*b +: 8] = wd[8*b +: 8];
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample before the edge, compare with
    // the model, then advance the model across the posedge.
    task automatic cyc(input logic s, input logic [1:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic ir);
        sel = s; addr = a; byteen = be; wdata = wd;
        #2;
        rd = rdata; ir = irq;
        check("model_rdata", rd, s ? model_read(a) : 32'd0);
        check("model_irq", 32'(ir), 32'(m_im & m_flag));
        @(posedge clk);
        model_step(s, a, be, wd);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] rd; logic ir;
        cyc(1'b1, a, 4'hF, wd, rd, ir);
    endtask

    typedef struct {
        logic        s;
        logic [1:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] rd;
        logic        ir;
        logic        found;
        logic [31:0] cnt_seq [5];
        logic        rs;
        logic [1:0]  ra;
        logic [3:0]  rbe;
        logic [31:0] rwd;

        reset = 1'b0; sel = 1'b0; addr = 2'd0; byteen = 4'd0; wdata = 32'd0;
        model_reset();
        @(negedge clk); @(negedge clk);

        // reset state
        sel = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check($sformatf("reset_rd%0d", a), rdata, (a == 1) ? RELOAD : 32'd0);
        end
        check("reset_irq", 32'(irq), 32'd0);
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // one-shot PRESET=5 run: COUNT 5..0, irq 7 edges after enable, cleared by CTRL write
        tbl[0]  = '{1'b1, 2'd1, 4'hF, 32'd5, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 4'hF, 32'h9, 32'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd0, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd5, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd4, 1'b0};
        tbl[6]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd3, 1'b0};
        tbl[7]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd2, 1'b0};
        tbl[8]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd1, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 4'h0, 32'd0, 32'd0, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 4'h0, 32'd0, 32'h8, 1'b1};
        tbl[11] = '{1'b1, 2'd0, 4'hF, 32'h8, 32'h8, 1'b1};
        tbl[12] = '{1'b1, 2'd0, 4'h0, 32'd0, 32'h8, 1'b0};
        tbl[13] = '{1'b0, 2'd2, 4'h0, 32'd0, 32'd0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].be, tbl[i].wd, rd, ir);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), 32'(ir), 32'(tbl[i].exp_irq));
        end

        // auto-reload PRESET=3: one-cycle pulse every PRESET+2 edges
        cnt_seq[0] = 32'd0; cnt_seq[1] = 32'd0; cnt_seq[2] = 32'd3;
        cnt_seq[3] = 32'd2; cnt_seq[4] = 32'd1;
        wr(ADDR_PRESET, 32'd3);
        wr(ADDR_CTRL, 32'hB);
        for (int j = 0; j < 22; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            check($sformatf("reload_irq_j%0d", j), 32'(ir), 32'((j > 0) && (j % 5 == 0)));
            check($sformatf("reload_cnt_j%0d", j), rd, cnt_seq[j % 5]);
        end
        wr(ADDR_CTRL, 32'h0);
        for (int j = 0; j < 3; j++) cyc(1'b0, 2'd0, 4'h0, 32'd0, rd, ir);

        // PRESET=0 behaves as 1: irq 3 edges after enable, no wrap
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            check($sformatf("p0_irq_j%0d", j), 32'(ir), 32'(j >= 3));
            check($sformatf("p0_nowrap_j%0d", j), 32'(rd == 32'hFFFF_FFFF), 32'd0);
            if (j >= 2) check($sformatf("p0_cnt_j%0d", j), rd, 32'd0);
        end
        wr(ADDR_CTRL, 32'h8);
        cyc(1'b1, ADDR_CTRL, 4'h0, 32'd0, rd, ir);
        check("p0_irq_cleared", 32'(ir), 32'd0);

        // disable mid-count: write issued while COUNT is 10, freezes at 9
        wr(ADDR_PRESET, 32'd20);
        wr(ADDR_CTRL, 32'h9);
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            if (rd == 32'd11) found = 1'b1;
        end
        check("freeze_reached_11", 32'(found), 32'd1);
        wr(ADDR_CTRL, 32'h8);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            check($sformatf("freeze_cnt_j%0d", j), rd, 32'd9);
            check($sformatf("freeze_irq_j%0d", j), 32'(ir), 32'd0);
        end
        cnt_seq[0] = 32'd9; cnt_seq[1] = 32'd9; cnt_seq[2] = 32'd2;
        cnt_seq[3] = 32'd1; cnt_seq[4] = 32'd0;
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h9);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            check($sformatf("restart_cnt_j%0d", j), rd, cnt_seq[j]);
            check($sformatf("restart_irq_j%0d", j), 32'(ir), 32'(j == 4));
        end
        wr(ADDR_CTRL, 32'h8);

        // IM=0: flag latches silently; low-byte CTRL write clears it
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h1);
        for (int j = 0; j < 7; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            check($sformatf("masked_irq_j%0d", j), 32'(ir), 32'd0);
        end
        cyc(1'b1, ADDR_CTRL, 4'b0001, 32'h8, rd, ir);
        cyc(1'b1, ADDR_CTRL, 4'h0, 32'd0, rd, ir);
        check("masked_ctrl", rd, 32'h8);
        check("masked_cleared_irq", 32'(ir), 32'd0);

        // IM set by a CTRL write on the expiry edge: flag survives and shows
        wr(ADDR_CTRL, 32'h1);
        for (int j = 0; j < 3; j++) cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
        cyc(1'b1, ADDR_CTRL, 4'b0001, 32'h8, rd, ir);
        check("expose_pre_irq", 32'(ir), 32'd0);
        cyc(1'b1, ADDR_CTRL, 4'h0, 32'd0, rd, ir);
        check("expose_irq", 32'(ir), 32'd1);
        check("expose_ctrl", rd, 32'h8);
        cyc(1'b1, ADDR_CTRL, 4'h0, 32'd0, rd, ir);
        check("expose_irq_hold", 32'(ir), 32'd1);
        wr(ADDR_CTRL, 32'h8);
        cyc(1'b1, ADDR_CTRL, 4'h0, 32'd0, rd, ir);
        check("expose_irq_cleared", 32'(ir), 32'd0);

        // asynchronous reset while irq is asserted
        wr(ADDR_PRESET, 32'd6);
        wr(ADDR_CTRL, 32'h9);
        for (int j = 0; j < 9; j++) cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
        check("prereset_irq", 32'(ir), 32'd1);
        reset = 1'b0; sel = 1'b1; byteen = 4'h0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check($sformatf("async_rst_rd%0d", a), rdata, (a == 1) ? RELOAD : 32'd0);
            check($sformatf("async_rst_irq%0d", a), 32'(irq), 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, ADDR_COUNT, 4'h0, 32'd0, rd, ir);
            check($sformatf("postreset_irq_j%0d", j), 32'(ir), 32'd0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 9) != 0);
            ra  = 2'($urandom_range(0, 3));
            rbe = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            rwd = $urandom;
            if (ra == ADDR_PRESET) rwd = 32'($urandom_range(0, 9));
            if (ra == ADDR_CTRL && $urandom_range(0, 2) != 0) rwd[0] = 1'b1;
            cyc(rs, ra, rbe, rwd, rd, ir);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
